spdif_audio_decoder: RTL and testbench

Recovers PCM samples from an oversampled S/PDIF (IEC 60958) biphase-mark line and delivers them on a valid/ready stream, one subframe per transfer, tagged left/right. Sits at the receive edge of the audio path, feeding the same sample stream format that the S/PDIF transmit path consumes (`{is_left, audio}`). It runs entirely in one system clock domain and needs no recovered clock: it measures run lengths between line transitions against a fixed oversampling ratio.

---
 rtl/spdif_audio_decoder.sv | 241 ++++++++++++++++++++++++
 tb/tb_spdif_audio_decoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_audio_decoder.sv
// S/PDIF biphase-mark receiver: run-length framing to a valid/ready sample stream.
// Define SPDIF_DECODER_PARITY_CHECK_EN to drop subframes that fail even parity.
module spdif_audio_decoder #(
    parameter int audio_width     = 16,
    parameter int clocks_per_cell = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   spdif,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [audio_width-1:0] o_audio,
    output logic                   o_is_left,
    output logic                   o_block_start,
    output logic                   o_locked,
    output logic                   o_overrun,
    output logic                   o_parity_error
);
    localparam int SAT = 8 * clocks_per_cell;
    localparam int RW  = $clog2(SAT + 1);
    localparam logic [RW-1:0] RUN_SAT = RW'(SAT);
    localparam logic [RW+1:0] T_G = (RW+2)'(clocks_per_cell);
    localparam logic [RW+1:0] T_1 = (RW+2)'(3 * clocks_per_cell);
    localparam logic [RW+1:0] T_2 = (RW+2)'(5 * clocks_per_cell);
    localparam logic [RW+1:0] T_3 = (RW+2)'(7 * clocks_per_cell);

    typedef enum logic [1:0] {HUNT, PREAMBLE, DATA} state_t;
    typedef enum logic [1:0] {RUN_BAD, RUN_1, RUN_2, RUN_3} run_t;

    logic          r_s1, r_s2, r_s3;
    logic [RW-1:0] r_run;
    logic          w_edge, w_sat;
    logic [RW+1:0] w_len2;
    run_t          w_cls;

    state_t      r_state, w_state_n;
    logic [1:0]  r_pcnt, w_pcnt_n;
    run_t        r_p1, r_p2, w_p1_n, w_p2_n;
    logic [4:0]  r_slot, w_slot_n;
    logic        r_half, w_half_n;
    logic [23:0] r_shift, w_shift_n;
    logic        r_left, w_left_n;
    logic        r_blk, w_blk_n;
    logic        r_locked, r_done;
    logic        w_err, w_ok, w_bit, w_start, w_done;
    logic        w_pbad, w_deliver;

    assign w_edge   = r_s2 ^ r_s3;
    assign w_sat    = (r_run == RUN_SAT) && !w_edge;
    // Twice the run length, so the half-UI thresholds stay integral
    assign w_len2   = {1'b0, r_run, 1'b0} + (RW+2)'(2);
    assign o_locked = r_locked;

    always_comb begin
        w_cls = RUN_BAD;
        if (w_len2 >= T_G) begin
            if (w_len2 < T_1)      w_cls = RUN_1;
            else if (w_len2 < T_2) w_cls = RUN_2;
            else if (w_len2 < T_3) w_cls = RUN_3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_s3  <= 1'b0;
            r_run <= '0;
        end else begin
            r_s1 <= spdif;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (w_edge)               r_run <= '0;
            else if (r_run != RUN_SAT) r_run <= r_run + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= HUNT;
            r_pcnt   <= 2'd0;
            r_p1     <= RUN_BAD;
            r_p2     <= RUN_BAD;
            r_slot   <= 5'd0;
            r_half   <= 1'b0;
            r_shift  <= '0;
            r_left   <= 1'b0;
            r_blk    <= 1'b0;
            r_locked <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pcnt  <= w_pcnt_n;
            r_p1    <= w_p1_n;
            r_p2    <= w_p2_n;
            r_slot  <= w_slot_n;
            r_half  <= w_half_n;
            r_shift <= w_shift_n;
            r_left  <= w_left_n;
            r_blk   <= w_blk_n;
            r_done  <= w_done;
            if (w_err)       r_locked <= 1'b0;
            else if (w_done) r_locked <= 1'b1;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_pcnt_n  = r_pcnt;
        w_p1_n    = r_p1;
        w_p2_n    = r_p2;
        w_slot_n  = r_slot;
        w_half_n  = r_half;
        w_shift_n = r_shift;
        w_left_n  = r_left;
        w_blk_n   = r_blk;
        w_err     = w_sat;
        w_ok      = 1'b0;
        w_bit     = 1'b0;
        w_start   = 1'b0;
        w_done    = 1'b0;
        if (w_edge && w_cls == RUN_BAD) begin
            w_err = 1'b1;
        end else if (w_edge) begin
            case (r_state)
                HUNT: begin
                    if (w_cls == RUN_3) begin
                        w_state_n = PREAMBLE;
                        w_pcnt_n  = 2'd1;
                    end
                end
                PREAMBLE: begin
                    w_pcnt_n = r_pcnt + 2'd1;
                    case (r_pcnt)
                        2'd0: w_err = (w_cls != RUN_3);
                        2'd1: w_p1_n = w_cls;
                        2'd2: w_p2_n = w_cls;
                        default: begin
                            w_start   = 1'b1;
                            w_state_n = DATA;
                            w_slot_n  = 5'd4;
                            w_half_n  = 1'b0;
                            // Runs 2..4 after the leading 3UI: B, M, W
                            case ({r_p1, r_p2, w_cls})
                                {RUN_1, RUN_1, RUN_3}: begin
                                    w_left_n = 1'b1;
                                    w_blk_n  = 1'b1;
                                end
                                {RUN_3, RUN_1, RUN_1}: begin
                                    w_left_n = 1'b1;
                                    w_blk_n  = 1'b0;
                                end
                                {RUN_2, RUN_1, RUN_2}: begin
                                    w_left_n = 1'b0;
                                    w_blk_n  = 1'b0;
                                end
                                default: begin
                                    w_start = 1'b0;
                                    w_err   = 1'b1;
                                end
                            endcase
                        end
                    endcase
                end
                DATA: begin
                    if (w_cls == RUN_1 && !r_half) begin
                        w_half_n = 1'b1;
                    end else if (w_cls == RUN_1) begin
                        w_ok  = 1'b1;
                        w_bit = 1'b1;
                    end else if (w_cls == RUN_2 && !r_half) begin
                        w_ok = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                    if (w_ok) begin
                        w_half_n = 1'b0;
                        if (r_slot <= 5'd27)
                            w_shift_n[r_slot - 5'd4] = w_bit;
                        if (r_slot == 5'd31) begin
                            w_done    = 1'b1;
                            w_state_n = PREAMBLE;
                            w_pcnt_n  = 2'd0;
                        end else begin
                            w_slot_n = r_slot + 5'd1;
                        end
                    end
                end
                default: w_err = 1'b1;
            endcase
        end
        if (w_err) begin
            w_state_n = HUNT;
            w_pcnt_n  = 2'd0;
            w_half_n  = 1'b0;
        end
    end

`ifdef SPDIF_DECODER_PARITY_CHECK_EN
    logic r_par, r_pbad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par  <= 1'b0;
            r_pbad <= 1'b0;
        end else begin
            r_pbad <= w_done & (r_par ^ w_bit);
            if (w_start)   r_par <= 1'b0;
            else if (w_ok) r_par <= r_par ^ w_bit;
        end
    end

    assign w_pbad         = r_pbad;
    assign o_parity_error = r_pbad;
`else
    assign w_pbad         = 1'b0;
    assign o_parity_error = 1'b0;
`endif

    assign w_deliver = r_done & ~w_pbad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid       <= 1'b0;
            o_audio       <= '0;
            o_is_left     <= 1'b0;
            o_block_start <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            o_overrun <= w_deliver & o_valid & ~o_ready;
            if (w_deliver && (!o_valid || o_ready)) begin
                o_valid       <= 1'b1;
                o_audio       <= r_shift[23 -: audio_width];
                o_is_left     <= r_left;
                o_block_start <= r_blk;
            end else if (o_valid && o_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spdif_audio_decoder.sv
// Bench for spdif_audio_decoder: encodes subframes as biphase-mark runs and
// scoreboards the expected {is_left, block_start, audio} sequence.
module tb_spdif_audio_decoder;
    localparam int C = 4;
    localparam int W = 16;
`ifdef SPDIF_DECODER_PARITY_CHECK_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         spdif = 1'b0;
    logic         o_ready = 1'b0;
    logic         o_valid, o_is_left, o_block_start;
    logic         o_locked, o_overrun, o_parity_error;
    logic [W-1:0] o_audio;

    int checks = 0;
    int errors = 0;
    int n_ovr = 0;
    int n_perr = 0;
    int n_xfer = 0;
    int rdy_mode = 1;
    logic [17:0] exp_q[$];
    logic [17:0] log_q[$];

    spdif_audio_decoder #(
        .audio_width(W),
        .clocks_per_cell(C)
    ) dut (
        .clk(clk),
        .reset(reset),
        .spdif(spdif),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_audio(o_audio),
        .o_is_left(o_is_left),
        .o_block_start(o_block_start),
        .o_locked(o_locked),
        .o_overrun(o_overrun),
        .o_parity_error(o_parity_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One line run of ui unit intervals, optionally +-1 cycle of jitter
    task automatic run(input int ui, input bit jit);
        int n;
        n = ui * C;
        if (jit) n = n + int'($urandom_range(0, 2)) - 1;
        spdif = ~spdif;
        repeat (n) tick();
    endtask

    // A 2UI slot split by a single-cycle pulse
    task automatic glitch_run();
        spdif = ~spdif;
        repeat (3) tick();
        spdif = ~spdif;
        tick();
        spdif = ~spdif;
        repeat (4) tick();
    endtask

    // kind: 0=B 1=M 2=W. mode: 0 normal, 1 bad parity, 2 glitch in slot 10,
    // 3 reset during slot 15, 4 normal but dropped by backpressure
    task automatic send_sub(input int kind, input logic [23:0] aud,
                            input bit jit, input int mode);
        logic [27:0] bits;
        logic [23:0] a;
        a = aud;
        if (mode == 2) a[6] = 1'b0;
        bits[23:0] = a;
        bits[24] = 1'b0;
        bits[25] = 1'($urandom);
        bits[26] = 1'($urandom);
        bits[27] = (^bits[26:0]) ^ (mode == 1);
        if (mode == 0 || (mode == 1 && PAR_EN == 0))
            exp_q.push_back({kind != 2, kind == 0, a[23:24-W]});
        case (kind)
            0: begin run(3, jit); run(1, jit); run(1, jit); run(3, jit); end
            1: begin run(3, jit); run(3, jit); run(1, jit); run(1, jit); end
            default: begin run(3, jit); run(2, jit); run(1, jit); run(2, jit); end
        endcase
        for (int s = 4; s < 32; s++) begin
            if (mode == 3 && s == 15) begin
                reset = 1'b1;
                #1;
                chk("reset_mid_outs",
                    {o_valid, o_locked, o_is_left, o_block_start,
                     o_overrun, o_parity_error, o_audio}, 32'd0);
            end
            if (mode == 3 && s == 16) reset = 1'b0;
            if (mode == 2 && s == 10) glitch_run();
            else if (bits[s-4]) begin run(1, jit); run(1, jit); end
            else run(2, jit);
        end
    endtask

    // Terminating edge for the last slot 31, then a silent line
    task automatic end_stream();
        spdif = ~spdif;
        repeat (40 * C) tick();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: o_ready = 1'b0;
                1: o_ready = 1'b1;
                default: o_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        logic [17:0] got;
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (o_overrun) n_ovr++;
                if (o_parity_error) n_perr++;
                if (o_valid && o_ready) begin
                    got = {o_is_left, o_block_start, o_audio};
                    log_q.push_back(got);
                    n_xfer++;
                    if (exp_q.size() == 0) begin
                        chk("xfer_unexpected", {14'd0, got}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("xfer", {14'd0, got}, {14'd0, e});
                    end
                end
            end
        end
    end

    initial begin
        int b, ov0, x0, p0;
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            spdif = ~spdif;
            repeat (2) tick();
        end
        chk("reset_outs",
            {o_valid, o_locked, o_is_left, o_block_start,
             o_overrun, o_parity_error, o_audio}, 32'd0);
        spdif = 1'b0;
        reset = 1'b0;
        repeat (100) tick();
        chk("idle_valid", o_valid, 0);
        chk("idle_locked", o_locked, 0);

        for (int pass = 0; pass < 2; pass++) begin
            b = log_q.size();
            send_sub(0, 24'h123456, pass[0], 0);
            send_sub(2, 24'hFEDCBA, pass[0], 0);
            chk("locked_after_first", o_locked, 1);
            send_sub(1, 24'h00FF00, pass[0], 0);
            end_stream();
            chk("stream_b", log_q[b], {2'b11, 16'h1234});
            chk("stream_w", log_q[b+1], {2'b00, 16'hFEDC});
            chk("stream_m", log_q[b+2], {2'b10, 16'h00FF});
            chk("stream_drained", exp_q.size(), 0);
        end

        rdy_mode = 0;
        repeat (2) tick();
        ov0 = n_ovr;
        x0 = n_xfer;
        send_sub(0, 24'h123456, 0, 0);
        send_sub(2, 24'hFEDCBA, 0, 4);
        end_stream();
        chk("bp_valid", o_valid, 1);
        chk("bp_audio", o_audio, 16'h1234);
        chk("bp_overrun", n_ovr - ov0, 1);
        rdy_mode = 1;
        repeat (10) tick();
        chk("bp_xfers", n_xfer - x0, 1);
        chk("bp_valid_low", o_valid, 0);
        chk("bp_drained", exp_q.size(), 0);

        p0 = n_perr;
        send_sub(0, 24'h0A0B0C, 0, 0);
        send_sub(2, 24'h5A5A5A, 0, 1);
        send_sub(1, 24'h777777, 0, 0);
        chk("par_locked", o_locked, 1);
        end_stream();
        chk("par_pulses", n_perr - p0, PAR_EN);
        chk("par_drained", exp_q.size(), 0);

        send_sub(0, 24'h111111, 0, 0);
        send_sub(2, 24'h222222, 0, 2);
        chk("glitch_unlocked", o_locked, 0);
        send_sub(1, 24'h333333, 0, 0);
        send_sub(2, 24'h444444, 0, 0);
        chk("glitch_relocked", o_locked, 1);
        end_stream();
        chk("glitch_drained", exp_q.size(), 0);

        send_sub(0, 24'hABCDEF, 0, 0);
        send_sub(2, 24'h13579B, 0, 3);
        send_sub(1, 24'h2468AC, 0, 0);
        end_stream();
        chk("reset_drained", exp_q.size(), 0);

        rdy_mode = 2;
        ov0 = n_ovr;
        for (int i = 0; i < 12; i++)
            send_sub(int'($urandom_range(0, 2)), 24'($urandom), 1, 0);
        end_stream();
        rdy_mode = 1;
        repeat (20) tick();
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_overrun", n_ovr - ov0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
